// File: rtl/ftseg_scan_decoder.sv
// Receive-side 14-segment scan decoder: qualifies stable multiplexed patterns and rebuilds a 4-digit BCD frame.
// Optional change-detect output is enabled by defining FTSEG_CHANGE_DET_EN.
module ftseg_scan_decoder #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned IDLE_TO    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] seg_in,
  input  logic [3:0]  dig_en,
  output logic [15:0] bcd_out,
  output logic [3:0]  blank,
  output logic [3:0]  err,
`ifdef FTSEG_CHANGE_DET_EN
  output logic        changed,
`endif
  output logic        frame_valid,
  output logic        timeout
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);
  localparam logic [9:0] IDLE_LAST  = 10'(IDLE_TO - 1);

  logic [18:0] prev_q, prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] slot_bcd_q, slot_bcd_d;
  logic [3:0]  slot_blank_q, slot_blank_d;
  logic [3:0]  slot_err_q, slot_err_d;
  logic [3:0]  mask_q, mask_d;
  logic [9:0]  idle_q, idle_d;
  logic [15:0] bcd_out_q, bcd_out_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  err_q, err_d;
  logic        frame_valid_q, frame_valid_d;
  logic        timeout_q, timeout_d;
`ifdef FTSEG_CHANGE_DET_EN
  logic        changed_q, changed_d;
`endif

  logic [18:0] sample;
  logic        dig_valid;
  logic        commit;
  logic [5:0]  dec;
  logic [3:0]  mask_new;

  // Result packing: {blank, err, bcd}
  function automatic logic [5:0] decode_pattern(input logic [14:0] pat);
    case (pat)
      15'h01FF: decode_pattern = 6'b00_0000;
      15'h7FDB: decode_pattern = 6'b00_0001;
      15'h127F: decode_pattern = 6'b00_0010;
      15'h067F: decode_pattern = 6'b00_0011;
      15'h4C7F: decode_pattern = 6'b00_0100;
      15'h247F: decode_pattern = 6'b00_0101;
      15'h207F: decode_pattern = 6'b00_0110;
      15'h0FFF: decode_pattern = 6'b00_0111;
      15'h007F: decode_pattern = 6'b00_1000;
      15'h047F: decode_pattern = 6'b00_1001;
      15'h7FFF: decode_pattern = 6'b10_1111;
      default:  decode_pattern = 6'b01_1110;
    endcase
  endfunction

  always_comb begin
    prev_d        = prev_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    slot_bcd_d    = slot_bcd_q;
    slot_blank_d  = slot_blank_q;
    slot_err_d    = slot_err_q;
    mask_d        = mask_q;
    idle_d        = idle_q;
    bcd_out_d     = bcd_out_q;
    blank_d       = blank_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;
    timeout_d     = 1'b0;
`ifdef FTSEG_CHANGE_DET_EN
    changed_d     = 1'b0;
`endif

    sample    = {seg_in, dig_en};
    prev_d    = sample;
    dig_valid = (dig_en == 4'b1110) || (dig_en == 4'b1101) ||
                (dig_en == 4'b1011) || (dig_en == 4'b0111);
    commit    = (cnt_q == STABLE_MAX) && !done_q;
    dec       = decode_pattern(prev_q[18:4]);
    mask_new  = mask_q | ~prev_q[3:0];

    // Commit is judged on prev, which only reaches a full count while holding a valid one-hot select
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (!prev_q[i]) begin
          slot_bcd_d[i*4 +: 4] = dec[3:0];
          slot_err_d[i]        = dec[4];
          slot_blank_d[i]      = dec[5];
        end
      end
      idle_d = '0;
      if (mask_new == 4'hF) begin
        bcd_out_d     = slot_bcd_d;
        blank_d       = slot_blank_d;
        err_d         = slot_err_d;
        frame_valid_d = 1'b1;
        mask_d        = '0;
`ifdef FTSEG_CHANGE_DET_EN
        changed_d     = {slot_bcd_d, slot_blank_d, slot_err_d} != {bcd_out_q, blank_q, err_q};
`endif
      end else begin
        mask_d = mask_new;
      end
    end else if (mask_q != 4'h0) begin
      if (idle_q == IDLE_LAST) begin
        mask_d    = '0;
        idle_d    = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + 10'd1;
      end
    end else begin
      idle_d = '0;
    end

    // A change of input starts a fresh run, so it must also re-arm the commit
    if (!dig_valid) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (sample == prev_q) begin
      cnt_d  = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 4'd1;
      done_d = done_q | commit;
    end else begin
      cnt_d  = 4'd1;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q        <= '1;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      slot_bcd_q    <= 16'hFFFF;
      slot_blank_q  <= 4'hF;
      slot_err_q    <= 4'h0;
      mask_q        <= '0;
      idle_q        <= '0;
      bcd_out_q     <= 16'hFFFF;
      blank_q       <= 4'hF;
      err_q         <= 4'h0;
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef FTSEG_CHANGE_DET_EN
      changed_q     <= 1'b0;
`endif
    end else begin
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      slot_bcd_q    <= slot_bcd_d;
      slot_blank_q  <= slot_blank_d;
      slot_err_q    <= slot_err_d;
      mask_q        <= mask_d;
      idle_q        <= idle_d;
      bcd_out_q     <= bcd_out_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
      timeout_q     <= timeout_d;
`ifdef FTSEG_CHANGE_DET_EN
      changed_q     <= changed_d;
`endif
    end
  end

  assign bcd_out     = bcd_out_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;
  assign timeout     = timeout_q;
`ifdef FTSEG_CHANGE_DET_EN
  assign changed     = changed_q;
`endif

endmodule

// File: tb/tb_ftseg_scan_decoder.sv
// Bench for ftseg_scan_decoder: directed scans plus random traffic against a run-length reference model.
// Also exercises the changed output when FTSEG_CHANGE_DET_EN is defined.
module tb_ftseg_scan_decoder;

  localparam int STABLE = 4;
  localparam int IDLE   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] seg_in;
  logic [3:0]  dig_en;
  logic [15:0] bcd_out;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;
  logic        timeout;
`ifdef FTSEG_CHANGE_DET_EN
  logic        changed;
`endif

  ftseg_scan_decoder #(.STABLE_CNT(STABLE), .IDLE_TO(IDLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .bcd_out     (bcd_out),
    .blank       (blank),
    .err         (err),
`ifdef FTSEG_CHANGE_DET_EN
    .changed     (changed),
`endif
    .frame_valid (frame_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int to_seen = 0;
  int ch_seen = 0;

  logic [14:0] digit_pat [10] = '{15'h01FF, 15'h7FDB, 15'h127F, 15'h067F, 15'h4C7F,
                                  15'h247F, 15'h207F, 15'h0FFF, 15'h007F, 15'h047F};

  // Reference model: run length of the last sample, per-digit slots, pending mask and idle age
  logic [18:0] m_prev;
  int          m_run;
  logic [3:0]  m_sbcd [4];
  logic        m_sbl  [4];
  logic        m_ser  [4];
  logic [3:0]  m_mask;
  int          m_idle;
  logic [15:0] exp_bcd;
  logic [3:0]  exp_blank;
  logic [3:0]  exp_err;
  logic        exp_fv;
  logic        exp_to;
  logic        exp_ch;

  function automatic void decode_ref(input logic [14:0] p, output logic [3:0] b,
                                     output logic bl, output logic er);
    b = 4'hE; bl = 1'b0; er = 1'b1;
    if (p == 15'h7FFF) begin
      b = 4'hF; bl = 1'b1; er = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (digit_pat[k] == p) begin
        b = 4'(k); er = 1'b0;
      end
    end
  endfunction

  task automatic model_edge(input logic r, input logic [14:0] s, input logic [3:0] d);
    logic [3:0]  b;
    logic        bl, er;
    logic [15:0] nb;
    logic [3:0]  nbl, ner;
    if (r) begin
      m_run = 0;
      for (int i = 0; i < 4; i++) begin
        m_sbcd[i] = 4'hF; m_sbl[i] = 1'b1; m_ser[i] = 1'b0;
      end
      m_mask = 4'h0; m_idle = 0;
      exp_bcd = 16'hFFFF; exp_blank = 4'hF; exp_err = 4'h0;
      exp_fv = 1'b0; exp_to = 1'b0; exp_ch = 1'b0;
    end else begin
      exp_fv = 1'b0; exp_to = 1'b0; exp_ch = 1'b0;
      if (m_run == STABLE) begin
        decode_ref(m_prev[18:4], b, bl, er);
        for (int i = 0; i < 4; i++) begin
          if (!m_prev[i]) begin
            m_sbcd[i] = b; m_sbl[i] = bl; m_ser[i] = er;
          end
        end
        m_mask = m_mask | ~m_prev[3:0];
        m_idle = 0;
        if (m_mask == 4'hF) begin
          for (int i = 0; i < 4; i++) begin
            nb[i*4 +: 4] = m_sbcd[i]; nbl[i] = m_sbl[i]; ner[i] = m_ser[i];
          end
          exp_ch = ({nb, nbl, ner} != {exp_bcd, exp_blank, exp_err});
          exp_bcd = nb; exp_blank = nbl; exp_err = ner;
          exp_fv = 1'b1;
          m_mask = 4'h0;
        end
      end else if (m_mask != 4'h0) begin
        m_idle++;
        if (m_idle == IDLE) begin
          m_mask = 4'h0; m_idle = 0; exp_to = 1'b1;
        end
      end else begin
        m_idle = 0;
      end
      if ($countones(d) == 3)
        m_run = ({s, d} == m_prev) ? ((m_run > STABLE) ? m_run : m_run + 1) : 1;
      else
        m_run = 0;
    end
    m_prev = {s, d};
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    check_val("bcd_out", bcd_out, exp_bcd);
    check_val("blank", {12'h0, blank}, {12'h0, exp_blank});
    check_val("err", {12'h0, err}, {12'h0, exp_err});
    check_val("frame_valid", {15'h0, frame_valid}, {15'h0, exp_fv});
    check_val("timeout", {15'h0, timeout}, {15'h0, exp_to});
`ifdef FTSEG_CHANGE_DET_EN
    check_val("changed", {15'h0, changed}, {15'h0, exp_ch});
    if (changed === 1'b1) ch_seen++;
`endif
    if (frame_valid === 1'b1) fv_seen++;
    if (timeout === 1'b1) to_seen++;
  endtask

  task automatic applyStimulus(input logic r, input logic [14:0] s, input logic [3:0] d);
    @(negedge clk);
    rst = r; seg_in = s; dig_en = d;
    @(posedge clk);
    model_edge(r, s, d);
    #1;
    checkOutput();
  endtask

  task automatic hold_digit(input logic [14:0] s, input int digit, input int n);
    logic [3:0] d;
    d = 4'hF;
    d[digit] = 1'b0;
    repeat (n) applyStimulus(1'b0, s, d);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus(1'b0, 15'h7FFF, 4'hF);
  endtask

  initial begin
    int fv0, to0, ch0;
    logic [15:0] held;
    rst = 1'b1; seg_in = 15'h7FFF; dig_en = 4'hF;

    // Reset state
    applyStimulus(1'b1, 15'h7FFF, 4'hF);
    applyStimulus(1'b1, 15'h7FFF, 4'hF);
    check_val("reset_bcd", bcd_out, 16'hFFFF);
    check_val("reset_blank", {12'h0, blank}, 16'h000F);

    // Basic scan 0..3, frame pulse right after the last hold
    fv0 = fv_seen;
    hold_digit(15'h01FF, 0, 4);
    hold_digit(15'h7FDB, 1, 4);
    hold_digit(15'h127F, 2, 4);
    hold_digit(15'h067F, 3, 4);
    check_val("no_early_frame", 16'(fv_seen - fv0), 16'd0);
    idle_cycles(1);
    check_val("scan_fv", {15'h0, frame_valid}, 16'h0001);
    check_val("scan_bcd", bcd_out, 16'h3210);
    check_val("scan_err", {12'h0, err}, 16'h0000);
    idle_cycles(2);

    // Short hold on digit 2 then a full hold: one frame total
    fv0 = fv_seen;
    hold_digit(15'h247F, 0, 4);
    hold_digit(15'h207F, 1, 4);
    hold_digit(15'h0FFF, 2, 3);
    idle_cycles(1);
    hold_digit(15'h0FFF, 2, 4);
    hold_digit(15'h007F, 3, 4);
    idle_cycles(2);
    check_val("short_hold_frames", 16'(fv_seen - fv0), 16'd1);
    check_val("short_hold_bcd", bcd_out, 16'h8765);

    // Blank and illegal digits
    hold_digit(15'h1234, 0, 4);
    hold_digit(15'h7FFF, 1, 4);
    hold_digit(15'h047F, 2, 4);
    hold_digit(15'h047F, 3, 4);
    idle_cycles(1);
    check_val("mixed_bcd", bcd_out, 16'h99FE);
    check_val("mixed_blank", {12'h0, blank}, 16'h0002);
    check_val("mixed_err", {12'h0, err}, 16'h0001);

    // Invalid selects keep the partial mask intact
    fv0 = fv_seen;
    hold_digit(15'h4C7F, 0, 4);
    hold_digit(15'h4C7F, 1, 4);
    repeat (5) applyStimulus(1'b0, 15'h01FF, 4'b1100);
    repeat (5) applyStimulus(1'b0, 15'h01FF, 4'hF);
    hold_digit(15'h4C7F, 2, 4);
    hold_digit(15'h4C7F, 3, 4);
    idle_cycles(1);
    check_val("invalid_sel_frames", 16'(fv_seen - fv0), 16'd1);
    check_val("invalid_sel_bcd", bcd_out, 16'h4444);

    // Idle watchdog discards a 3-digit partial frame
    to0 = to_seen;
    held = bcd_out;
    hold_digit(15'h01FF, 0, 4);
    hold_digit(15'h01FF, 1, 4);
    hold_digit(15'h01FF, 2, 4);
    idle_cycles(20);
    check_val("timeout_count", 16'(to_seen - to0), 16'd1);
    check_val("timeout_bcd_held", bcd_out, held);
    hold_digit(15'h7FDB, 0, 4);
    hold_digit(15'h7FDB, 1, 4);
    hold_digit(15'h7FDB, 2, 4);
    hold_digit(15'h7FDB, 3, 4);
    idle_cycles(1);
    check_val("after_timeout_bcd", bcd_out, 16'h1111);

    // Reset on the final commit edge wins
    hold_digit(15'h127F, 0, 4);
    hold_digit(15'h127F, 1, 4);
    hold_digit(15'h127F, 2, 4);
    hold_digit(15'h127F, 3, 4);
    applyStimulus(1'b1, 15'h127F, 4'b0111);
    idle_cycles(1);
    check_val("rst_commit_fv", {15'h0, frame_valid}, 16'h0000);
    check_val("rst_commit_bcd", bcd_out, 16'hFFFF);

    // Two identical frames back to back
    ch0 = ch_seen;
    repeat (2) begin
      hold_digit(15'h067F, 0, 4);
      hold_digit(15'h067F, 1, 4);
      hold_digit(15'h067F, 2, 4);
      hold_digit(15'h067F, 3, 4);
      idle_cycles(1);
    end
`ifdef FTSEG_CHANGE_DET_EN
    check_val("changed_once", 16'(ch_seen - ch0), 16'd1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 200; n++) begin
      int sel, kind, hold;
      logic [14:0] p;
      logic [3:0]  d;
      sel  = int'($urandom_range(0, 99));
      kind = int'($urandom_range(0, 99));
      hold = int'($urandom_range(1, 6));
      if (kind < 65)      p = digit_pat[$urandom_range(0, 9)];
      else if (kind < 80) p = 15'h7FFF;
      else                p = 15'($urandom);
      d = 4'hF;
      d[$urandom_range(0, 3)] = 1'b0;
      if (sel < 6) d = 4'($urandom);
      if (sel == 99) applyStimulus(1'b1, p, d);
      else repeat (hold) applyStimulus(1'b0, p, d);
    end
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftseg_scan_decoder.md
Name: ftseg_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-14-segment display decoder.
- Observes a multiplexed, active-low 15-bit segment bus plus an active-low digit-enable bus, qualifies stable patterns, and decodes each pattern back to BCD.
- Assembles a 4-digit packed BCD frame.
- Used as a loopback checker and self-test monitor on the display path.

Parameters:
- STABLE_CNT, 4: consecutive identical samples required before a digit is committed. Legal range 2..15; counter width is 4 bits.
- IDLE_TO, 1023: cycles without any commit before the partial frame is discarded. Legal range 1..1023; counter width is 10 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_in  input  15  observed segment pattern, active-low; bit 14 is the first segment of the display encoding.
- dig_en  input  4  digit select, active-low one-hot; bit i low selects digit i.
- bcd_out  output  16  packed frame; [15:12] is digit 3 … [3:0] is digit 0.
- blank  output  4  per-digit flag: pattern was all-off.
- err  output  4  per-digit flag: pattern was not a legal code.
- frame_valid  output  1  one-cycle pulse when bcd_out/blank/err update.
- timeout  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (rst high at an edge):
  - bcd_out=16'hFFFF, blank=4'hF, err=4'h0, frame_valid=0, timeout=0.
  - Internal slots = F/blank, seen-mask = 0, stability counter = 0, commit-done flag = 0, idle counter = 0.
  - Reset dominates every other event, including an in-flight commit.
- Sample register: {seg_in, dig_en} is captured every edge into prev.
- dig_en is valid only when exactly one bit is 0.
- Stability counter (cnt), updated each edge:
  - invalid dig_en: cnt<=0, done<=0.
  - valid dig_en and {seg_in, dig_en}==prev: cnt<=cnt+1, saturating at STABLE_CNT.
  - otherwise: cnt<=1, done<=0.
- Commit:
  - Condition: cnt==STABLE_CNT and done==0.
  - Action: the decoded value of prev is written to slot[i], mask[i]<=1, done<=1. Exactly one commit per stable run.
- Decode, with pattern written as 15-bit hex:
  - 0x01FF→0, 0x7FDB→1, 0x127F→2, 0x067F→3, 0x4C7F→4, 0x247F→5, 0x207F→6, 0x0FFF→7, 0x007F→8, 0x047F→9.
  - 0x7FFF→bcd F, blank=1.
  - Any other pattern→bcd E, err=1.
  - blank and err are never both 1 for one digit.
- Latency:
  - A pair held from edge 1 through edge STABLE_CNT commits at edge STABLE_CNT+1.
- Frame completion:
  - Trigger: a commit makes mask|(1<<i)==4'hF.
  - At that same edge: bcd_out/blank/err load all four slots (including the new value), frame_valid is high for the following cycle, and mask<=0.
  - Outputs hold until the next frame completion or reset.
- Recommitting a digit already in mask overwrites its slot; mask is unchanged and no frame is emitted.
- Idle watchdog:
  - The idle counter increments on each edge without a commit while mask!=0, and clears on a commit or when mask==0.
  - When it reaches IDLE_TO: mask<=0, idle<=0, timeout pulses for 1 cycle, and bcd_out is unchanged.
- If a frame completion and a timeout fall on the same edge, the commit wins and timeout does not fire.
- A glitch mid-run (value differs for 1 cycle) restarts cnt at 1. A returning pattern needs a full STABLE_CNT again.

Optional Feature:
- Macro: FTSEG_CHANGE_DET_EN.
- Defined:
  - Adds output changed (1 bit, reset 0).
  - changed pulses together with frame_valid only when the new {bcd_out, blank, err} differs from the previous frame value.
  - The first frame after reset compares against reset values.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then scan digits 0..3 with patterns 0x01FF, 0x7FDB, 0x127F, 0x067F, each held 4 cycles (STABLE_CNT=4) → one frame_valid pulse, bcd_out=16'h3210, blank=0, err=0; the pulse occurs at the edge after the 4th hold cycle of digit 3.
- Digit 2 pattern held only 3 cycles, then digit 2 is shown again for 4 cycles → a single commit, and no frame until all four digits are committed.
- Digit 1 shows 0x7FFF and digit 0 shows 0x1234, others legal 9 (0x047F) → bcd_out=16'h99FE, blank=4'b0010, err=4'b0001.
- dig_en=4'b1100 or 4'hF for 10 cycles → no commit; cnt stays 0; mask unchanged.
- Commit digits 0..2, then stop (IDLE_TO=16) → timeout pulses 16 cycles after the last commit; bcd_out keeps the prior frame; a new full scan then produces a normal frame.
- rst asserted on the commit edge of the final digit → no frame_valid, outputs at reset values; with FTSEG_CHANGE_DET_EN, repeating an identical frame twice → changed asserts on the first only.
